regs_wb: RTL and testbench

//  Write-side controller for the 32x32 register file. Merges single-cycle ALU results and

---
 rtl/regs_wb_if.sv | 32 +++
 rtl/regs_wb.sv | 121 ++++++++++++
 tb/tb_regs_wb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/regs_wb_if.sv
// Register-file write-side bus: ALU results, memory results, hazard query and write port.
interface regs_wb_if #(
  parameter int DW = 32
);
  logic          alu_valid_i;
  logic [4:0]    alu_rd_i;
  logic [DW-1:0] alu_data_i;
  logic          mem_valid_i;
  logic          mem_ready_o;
  logic [4:0]    mem_rd_i;
  logic [DW-1:0] mem_data_i;
  logic [4:0]    chk_rs1_i;
  logic [4:0]    chk_rs2_i;
  logic          hazard_o;
  logic          wen_o;
  logic [4:0]    rd_o;
  logic [DW-1:0] rd_data_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output mem_valid_i, mem_rd_i, mem_data_i,
    output chk_rs1_i, chk_rs2_i,
    input  mem_ready_o, hazard_o, wen_o, rd_o, rd_data_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  mem_valid_i, mem_rd_i, mem_data_i,
    input  chk_rs1_i, chk_rs2_i,
    output mem_ready_o, hazard_o, wen_o, rd_o, rd_data_o
  );
endinterface

// File: rtl/regs_wb.sv
// Register-file write-port arbiter: ALU results win, memory results are bypassed or
// buffered in order; younger ALU writes kill stale buffered writes to the same rd.
module regs_wb #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic     clk,
  input  logic     rst,
  regs_wb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [4:0]    ent_rd_q   [DEPTH];
  logic [DW-1:0] ent_data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          wen_q, wen_d;
  logic [4:0]    rd_q, rd_d;
  logic [DW-1:0] data_q, data_d;

  logic alu_w, mem_acc, mem_nz, empty, pop, bypass, push;

  assign bus.mem_ready_o = (count_q != DEPTH[AW:0]);
  assign alu_w   = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
  assign mem_acc = bus.mem_valid_i && bus.mem_ready_o;
  assign mem_nz  = mem_acc && (bus.mem_rd_i != 5'd0);
  assign empty   = (count_q == '0);
  assign pop     = !alu_w && !empty;
  assign bypass  = !alu_w && empty && mem_nz;
  // A memory beat racing an ALU write to the same rd is older, so it is simply dropped.
  assign push    = mem_nz && !bypass && !(alu_w && (bus.mem_rd_i == bus.alu_rd_i));

  always_comb begin
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alu_w) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (ent_rd_q[i] == bus.alu_rd_i)) vld_d[i] = 1'b0;
      end
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + AW'(1);
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_comb begin
    wen_d  = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (alu_w) begin
      wen_d  = 1'b1;
      rd_d   = bus.alu_rd_i;
      data_d = bus.alu_data_i;
    end else if (pop) begin
      // A killed head still consumes a cycle but leaves the write port idle.
      if (vld_q[head_q]) begin
        wen_d  = 1'b1;
        rd_d   = ent_rd_q[head_q];
        data_d = ent_data_q[head_q];
      end
    end else if (bypass) begin
      wen_d  = 1'b1;
      rd_d   = bus.mem_rd_i;
      data_d = bus.mem_data_i;
    end
  end

  always_comb begin
    bus.hazard_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (bus.chk_rs1_i != 5'd0) && (ent_rd_q[i] == bus.chk_rs1_i))
        bus.hazard_o = 1'b1;
      if (vld_q[i] && (bus.chk_rs2_i != 5'd0) && (ent_rd_q[i] == bus.chk_rs2_i))
        bus.hazard_o = 1'b1;
    end
    if (mem_acc && (bus.chk_rs1_i != 5'd0) && (bus.mem_rd_i == bus.chk_rs1_i))
      bus.hazard_o = 1'b1;
    if (mem_acc && (bus.chk_rs2_i != 5'd0) && (bus.mem_rd_i == bus.chk_rs2_i))
      bus.hazard_o = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[tail_q]   <= bus.mem_rd_i;
      ent_data_q[tail_q] <= bus.mem_data_i;
    end
  end

  assign bus.wen_o     = wen_q;
  assign bus.rd_o      = rd_q;
  assign bus.rd_data_o = data_q;
endmodule

// File: tb/tb_regs_wb.sv
// Directed bench for regs_wb: arbitration, buffering, kill, x0 discard, hazard and reset.
module tb_regs_wb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  regs_wb_if #(.DW(32)) bus ();

  regs_wb #(.DEPTH(4), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid_i = 1'b0;
    bus.alu_rd_i    = '0;
    bus.alu_data_i  = '0;
    bus.mem_valid_i = 1'b0;
    bus.mem_rd_i    = '0;
    bus.mem_data_i  = '0;
    bus.chk_rs1_i   = '0;
    bus.chk_rs2_i   = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = rd;
    bus.alu_data_i  = d;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [31:0] d);
    bus.mem_valid_i = 1'b1;
    bus.mem_rd_i    = rd;
    bus.mem_data_i  = d;
  endtask

  task automatic wport(input string tag, input logic w, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".wen"}, 32'(bus.wen_o), 32'(w));
    chk({tag, ".rd"}, 32'(bus.rd_o), 32'(rd));
    chk({tag, ".data"}, bus.rd_data_o, d);
  endtask

  initial begin
    idle();
    #12;
    wport("reset", 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset.ready", 32'(bus.mem_ready_o), 32'd1);

    // 1: ALU write
    tick();
    alu(5'd5, 32'hA5A5A5A5);
    tick();
    idle();
    wport("alu", 1'b1, 5'd5, 32'hA5A5A5A5);
    tick();
    wport("alu_idle", 1'b0, 5'd5, 32'hA5A5A5A5);

    // 2: memory bypass on idle bus
    mem(5'd3, 32'h11);
    bus.chk_rs1_i = 5'd3;
    #1;
    chk("bypass.hazard_accept", 32'(bus.hazard_o), 32'd1);
    tick();
    idle();
    wport("bypass", 1'b1, 5'd3, 32'h11);
    bus.chk_rs1_i = 5'd3;
    #1;
    chk("bypass.no_entry", 32'(bus.hazard_o), 32'd0);

    // 3: fill buffer behind a busy ALU, then drain in order
    for (int i = 0; i < 6; i++) begin
      idle();
      alu(5'(10 + i), 32'h100 + 32'(i));
      if (i < 4) mem(5'(20 + i), 32'h200 + 32'(i));
      if (i == 4) begin
        mem(5'd24, 32'h204);
        bus.chk_rs1_i = 5'd22;
        bus.chk_rs2_i = 5'd24;
        #1;
        chk("full.ready", 32'(bus.mem_ready_o), 32'd0);
        chk("full.hazard", 32'(bus.hazard_o), 32'd1);
        bus.chk_rs1_i = 5'd0;
        #1;
        chk("full.hazard_rejected", 32'(bus.hazard_o), 32'd0);
      end
      tick();
      wport($sformatf("fill%0d", i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      tick();
      wport($sformatf("drain%0d", j), 1'b1, 5'(20 + j), 32'h200 + 32'(j));
    end
    chk("drain.ready", 32'(bus.mem_ready_o), 32'd1);
    tick();
    chk("drain.empty", 32'(bus.wen_o), 32'd0);

    // 4: ALU write kills buffered entry with same rd
    alu(5'd1, 32'h33);
    mem(5'd7, 32'h77);
    tick();
    idle();
    wport("kill.pre", 1'b1, 5'd1, 32'h33);
    bus.chk_rs1_i = 5'd7;
    #1;
    chk("kill.hazard_before", 32'(bus.hazard_o), 32'd1);
    alu(5'd7, 32'h22);
    tick();
    idle();
    wport("kill.alu", 1'b1, 5'd7, 32'h22);
    bus.chk_rs1_i = 5'd7;
    #1;
    chk("kill.hazard_after", 32'(bus.hazard_o), 32'd0);
    tick();
    wport("kill.bubble", 1'b0, 5'd7, 32'h22);
    tick();
    chk("kill.empty", 32'(bus.wen_o), 32'd0);

    // same-cycle mem beat to the ALU's rd is dropped
    alu(5'd8, 32'h1);
    mem(5'd8, 32'h2);
    tick();
    idle();
    wport("drop", 1'b1, 5'd8, 32'h1);
    bus.chk_rs1_i = 5'd8;
    #1;
    chk("drop.hazard", 32'(bus.hazard_o), 32'd0);
    tick();
    chk("drop.idle", 32'(bus.wen_o), 32'd0);

    // 5: x0 writes are discarded
    alu(5'd0, 32'hDEAD);
    mem(5'd0, 32'hBEEF);
    #1;
    chk("x0.hazard", 32'(bus.hazard_o), 32'd0);
    tick();
    idle();
    chk("x0.wen", 32'(bus.wen_o), 32'd0);
    tick();
    chk("x0.nopop", 32'(bus.wen_o), 32'd0);

    // 6: hazard on buffered rd, then reset mid-drain
    alu(5'd2, 32'h2);
    mem(5'd9, 32'h99);
    tick();
    idle();
    alu(5'd4, 32'h4);
    mem(5'd11, 32'hBB);
    tick();
    idle();
    wport("rst.pre", 1'b1, 5'd4, 32'h4);
    bus.chk_rs2_i = 5'd9;
    #1;
    chk("rst.hazard9", 32'(bus.hazard_o), 32'd1);
    tick();
    wport("rst.pop9", 1'b1, 5'd9, 32'h99);
    bus.chk_rs2_i = 5'd11;
    #1;
    chk("rst.hazard11", 32'(bus.hazard_o), 32'd1);
    rst = 1'b0;
    #1;
    wport("rst.async", 1'b0, 5'd0, 32'h0);
    chk("rst.hazard_clr", 32'(bus.hazard_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.ready", 32'(bus.mem_ready_o), 32'd1);
    tick();
    chk("rst.discarded", 32'(bus.wen_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
